// File: rtl/proc_ctrl.sv
// -----------------------------------------------------------------------------
// proc_ctrl -- instruction-sequencing controller for a small accumulator CPU.
//
// Walks every instruction through FETCH -> DECODE -> EXEC. Datapath strobes are
// decoded combinationally from the current state, the opcode and, when memory
// wait states are enabled, mem_rdy. HLT parks the controller in HALT, which
// only a reset leaves.
//
// Configuration macro:
//   PROC_CTRL_MEMWAIT_EN  when defined, FETCH and the memory EXEC instructions
//                         (LDA, STA) stretch until mem_rdy=1. When undefined,
//                         mem_rdy is ignored and every state lasts one cycle.
//
// Ports:
//   clk         system clock, rising edge
//   CLB         asynchronous active-low reset
//   run         start/continue; sampled in IDLE and when EXEC completes
//   opcode      instruction bits [7:4]; only looked at in EXEC
//   zero_flag   accumulator zero status (JZ condition)
//   carry_flag  accumulator carry status (JC condition)
//   mem_rdy     memory handshake (only with PROC_CTRL_MEMWAIT_EN)
//   load_ir, inc_pc, load_pc, load_acc   datapath register strobes
//   acc_sel     ACC source: 0 ALU, 1 memory, 2 immediate
//   alu_op      0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT
//   mem_rd, mem_wr  memory strobes
//   addr_sel    memory address source: 0 PC, 1 operand
//   halted      high while in HALT
//   state       IDLE 0, FETCH 1, DECODE 2, EXEC 3, HALT 4
//   retired     wrapping count of completed instructions
// -----------------------------------------------------------------------------
module proc_ctrl #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 CLB,
    input  logic                 run,
    input  logic [3:0]           opcode,
    input  logic                 zero_flag,
    input  logic                 carry_flag,
    input  logic                 mem_rdy,
    output logic                 load_ir,
    output logic                 inc_pc,
    output logic                 load_pc,
    output logic                 load_acc,
    output logic [1:0]           acc_sel,
    output logic [2:0]           alu_op,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 addr_sel,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_LDI = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 exec_done;
    logic                 mem_ok;
    logic [3:0]           alu_idx;

`ifdef PROC_CTRL_MEMWAIT_EN
    assign mem_ok = mem_rdy;
`else
    // Memory always answers in the same cycle; mem_rdy is deliberately unused.
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign mem_ok         = 1'b1;
`endif

    // ALU opcodes 0x3..0x7 map onto alu_op 0..4.
    assign alu_idx = opcode - 4'd3;

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statements leaves one unassigned (no latches).
        state_d   = state_q;
        retired_d = retired_q;
        exec_done = 1'b0;
        load_ir   = 1'b0;
        inc_pc    = 1'b0;
        load_pc   = 1'b0;
        load_acc  = 1'b0;
        acc_sel   = 2'd0;
        alu_op    = 3'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        addr_sel  = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_rd   = 1'b1;
                addr_sel = 1'b0;
                // IR load and PC increment happen once, on the ready cycle.
                if (mem_ok) begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_EXEC;
            end

            S_EXEC: begin
                exec_done = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        mem_rd    = 1'b1;
                        addr_sel  = 1'b1;
                        acc_sel   = 2'd1;
                        load_acc  = mem_ok;
                        exec_done = mem_ok;
                    end
                    OP_STA: begin
                        mem_wr    = 1'b1;
                        addr_sel  = 1'b1;
                        exec_done = mem_ok;
                    end
                    4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        load_acc = 1'b1;
                        acc_sel  = 2'd0;
                        alu_op   = alu_idx[2:0];
                    end
                    OP_JMP: load_pc = 1'b1;
                    OP_JZ:  load_pc = zero_flag;
                    OP_JC:  load_pc = carry_flag;
                    OP_LDI: begin
                        load_acc = 1'b1;
                        acc_sel  = 2'd2;
                    end
                    default: ;  // NOP (0x0, 0xC-0xE) and HLT drive no strobes
                endcase

                // HLT also counts as a retired instruction.
                if (exec_done) begin
                    retired_d = retired_q + CNT_WIDTH'(1);
                    if (opcode == OP_HLT) state_d = S_HALT;
                    else if (run)         state_d = S_FETCH;
                    else                  state_d = S_IDLE;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode from state_q, so forcing state_q to IDLE here also clears
    // every strobe the moment CLB falls.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
